// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types for the multi-cycle ALU.
//   alu_op_e    - opcode encoding carried on the op port
//   alu_state_e - control FSM states (IDLE, MUL, HOLD)
//   clog2_min1  - counter width helper that never returns 0
package alu_mc_pkg;

    typedef enum logic [1:0] {
        ALU_NOP = 2'b00,
        ALU_ADD = 2'b01,
        ALU_SUB = 2'b10,
        ALU_MUL = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_mc_mul_step.sv
// alu_mc_mul_step: one iteration of the chunked multiplier.
//   a        - full-width multiplicand
//   b_chunk  - MUL_W-bit slice of the multiplier for this step
//   step     - chunk index, sets the shift of the partial product
//   acc      - running accumulator
//   acc_next - acc + (a * b_chunk) << (step*MUL_W), truncated to WIDTH
// Purely combinational so the WIDTH x MUL_W product maps onto a single
// DSP-sized multiplier.
module alu_mc_mul_step #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_W  = 16,
    parameter int unsigned STEP_W = 1
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [MUL_W-1:0]  b_chunk,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  acc,
    output logic [WIDTH-1:0]  acc_next
);

    localparam int unsigned SH_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] b_ext;
    logic [WIDTH-1:0] prod;
    logic [SH_W-1:0]  shamt;

    // Only the low WIDTH bits of the product can survive the truncating
    // shift-accumulate, so the product is kept at WIDTH bits.
    assign b_ext    = WIDTH'(b_chunk);
    assign prod     = a * b_ext;
    assign shamt    = SH_W'(step) * SH_W'(MUL_W);
    assign acc_next = acc + (prod << shamt);

endmodule

// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle integer ALU (ADD, SUB, NOP, iterative MUL)
// with valid/ready handshakes on operand and result sides.
//   clk, rst (async active-low), clr (sync active-high clear)
//   in_valid/in_ready, op, key_in, in_a, in_b   - operand beat
//   out_valid/out_ready, out, key_out           - result beat
//   flag_zero, flag_carry, flag_err             - result flags
// ADD/SUB/NOP complete with latency 1; MUL takes WIDTH/MUL_W cycles.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned KEY_W   = 8,
    parameter int unsigned MUL_W   = 16,
    parameter bit          HAS_ADD = 1'b1,
    parameter bit          HAS_MUL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [KEY_W-1:0] key_in,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [KEY_W-1:0] key_out,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             flag_err
);

    localparam int unsigned N      = WIDTH / MUL_W;
    localparam int unsigned STEP_W = clog2_min1(N);

    if (!HAS_ADD && !HAS_MUL) begin : g_cfg_no_ops
        $error("alu_mc: HAS_ADD and HAS_MUL cannot both be 0");
    end
    if ((WIDTH % MUL_W) != 0) begin : g_cfg_width
        $error("alu_mc: WIDTH must be a multiple of MUL_W");
    end

    alu_state_e       state_q, state_d;
    alu_op_e          op_e;

    logic             valid_d;
    logic [WIDTH-1:0] out_d;
    logic [KEY_W-1:0] key_d;
    logic             zero_d, carry_d, err_d;

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [WIDTH-1:0]  mul_a_q, mul_a_d;
    logic [WIDTH-1:0]  mul_b_q, mul_b_d;
    logic [KEY_W-1:0]  mul_key_q, mul_key_d;
    logic [MUL_W-1:0]  mul_chunk;
    logic [WIDTH-1:0]  acc_next;

    logic             in_fire, out_fire;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_borrow;

    logic             op_ok;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    assign op_e = alu_op_e'(op);

    // Operands are also accepted from HOLD on the cycle the held result
    // drains, which gives back-to-back single-cycle ops full throughput.
    assign in_ready = (state_q != ST_MUL) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign add_sum    = {1'b0, in_a} + {1'b0, in_b};
    assign sub_diff   = in_a - in_b;
    assign sub_borrow = in_a < in_b;

    assign mul_chunk = mul_b_q[step_q*MUL_W +: MUL_W];

    alu_mc_mul_step #(
        .WIDTH  (WIDTH),
        .MUL_W  (MUL_W),
        .STEP_W (STEP_W)
    ) u_mul_step (
        .a        (mul_a_q),
        .b_chunk  (mul_chunk),
        .step     (step_q),
        .acc      (acc_q),
        .acc_next (acc_next)
    );

    // Single-cycle result for the incoming op; a disabled op yields 0.
    always_comb begin
        op_ok     = 1'b1;
        res       = '0;
        res_carry = 1'b0;
        case (op_e)
            ALU_NOP: res = in_a;
            ALU_ADD: begin
                if (HAS_ADD) begin
                    res       = add_sum[WIDTH-1:0];
                    res_carry = add_sum[WIDTH];
                end else begin
                    op_ok = 1'b0;
                end
            end
            ALU_SUB: begin
                if (HAS_ADD) begin
                    res       = sub_diff;
                    res_carry = sub_borrow;
                end else begin
                    op_ok = 1'b0;
                end
            end
            ALU_MUL: op_ok = HAS_MUL;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = out_valid;
        out_d     = out;
        key_d     = key_out;
        zero_d    = flag_zero;
        carry_d   = flag_carry;
        err_d     = flag_err;
        acc_d     = acc_q;
        step_d    = step_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_key_d = mul_key_q;

        if (state_q == ST_MUL) begin
            acc_d  = acc_next;
            step_d = step_q + 1'b1;
            if (step_q == STEP_W'(N - 1)) begin
                out_d   = acc_next;
                key_d   = mul_key_q;
                zero_d  = (acc_next == '0);
                carry_d = 1'b0;
                err_d   = 1'b0;
                valid_d = 1'b1;
                step_d  = '0;
                state_d = ST_HOLD;
            end
        end else begin
            if (out_fire) begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
            if (in_fire) begin
                if (op_e == ALU_MUL && op_ok) begin
                    mul_a_d   = in_a;
                    mul_b_d   = in_b;
                    mul_key_d = key_in;
                    acc_d     = '0;
                    step_d    = '0;
                    valid_d   = 1'b0;
                    state_d   = ST_MUL;
                end else begin
                    out_d   = res;
                    key_d   = key_in;
                    zero_d  = (res == '0);
                    carry_d = res_carry;
                    err_d   = !op_ok;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            out_valid  <= 1'b0;
            out        <= '0;
            key_out    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_err   <= 1'b0;
            acc_q      <= '0;
            step_q     <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_key_q  <= '0;
        end else if (clr) begin
            state_q    <= ST_IDLE;
            out_valid  <= 1'b0;
            out        <= '0;
            key_out    <= '0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_err   <= 1'b0;
            acc_q      <= '0;
            step_q     <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_key_q  <= '0;
        end else begin
            state_q    <= state_d;
            out_valid  <= valid_d;
            out        <= out_d;
            key_out    <= key_d;
            flag_zero  <= zero_d;
            flag_carry <= carry_d;
            flag_err   <= err_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_key_q  <= mul_key_d;
        end
    end

endmodule
